skel_frame_server: RTL
======================

SKEL_FRAME_SERVER -- requirements
Module: skel_frame_server

Interface
REQ-001 Parameters: N, default 8, frame edge in pixels (frame = N*N); bitSize, default 6, mask address MSB index; pixelWidth, default 8, pixel bits; MAX_ITER, default 16, iteration cap.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 host_we  in  1  host frame-load write strobe, honoured only in IDLE.
REQ-005 host_addr  in  bitSize+1  host load/read pixel index.
REQ-006 host_wdata  in  pixelWidth  host load pixel.
REQ-007 host_rdata  out  pixelWidth  frame pixel at host_addr, registered, 1-cycle latency.
REQ-008 host_rharris  out  1  corner bit at host_addr, registered, 1-cycle latency.
REQ-009 start  in  1  single-cycle pulse, begins a skeletonization run from IDLE or DONE.
REQ-010 mask_we  out  1  frame-stream strobe to the convolution unit.
REQ-011 mask_data  out  pixelWidth  streamed pixel.
REQ-012 mask_wr_en  in  1  write-back valid from the convolution unit.
REQ-013 mask_addr  in  bitSize+1  write-back pixel index.
REQ-014 mask_pixel  in  pixelWidth  write-back pixel value.
REQ-015 mask_harris  in  1  write-back corner bit.
REQ-016 busy  out  1  high in STREAM, WAIT_WB, CAPTURE, CHECK.
REQ-017 done  out  1  high in DONE, held until start.
REQ-018 iter_count  out  8  completed passes in the current run, saturating at 255.
REQ-019 converged  out  1  in DONE: 1 if the last pass changed no pixel, 0 if MAX_ITER ended the run.

Function
REQ-020 Storage: frame RAM and harris RAM of N*N entries each, single write port shared by host load and write-back capture.
REQ-021 FSM states IDLE, STREAM, WAIT_WB, CAPTURE, CHECK, DONE; start in IDLE or DONE -> STREAM with iter_count=0, changed=0.
REQ-022 STREAM: mask_we=1 for exactly 2*N*N consecutive cycles; each pixel index k (0..N*N-1) held on mask_data for 2 cycles, k advancing every second cycle (matches the convolution unit's half-rate flip); then -> WAIT_WB with mask_we=0.
REQ-023 WAIT_WB: -> CAPTURE on the first cycle mask_wr_en=1; if mask_wr_en is not seen within 4*N*N cycles, -> DONE with converged=0 (timeout).
REQ-024 CAPTURE: every cycle mask_wr_en=1, write mask_pixel and mask_harris at mask_addr; if mask_pixel differs from the stored pixel, set changed=1; duplicate writes to the same address are legal and idempotent.
REQ-025 CAPTURE -> CHECK on the first cycle mask_wr_en=0; iter_count increments on that transition.
REQ-026 CHECK (1 cycle): changed=1 and iter_count<MAX_ITER -> STREAM with changed cleared; otherwise -> DONE, converged = ~changed.
REQ-027 mask_addr >= N*N is ignored (no write, no changed update).
REQ-028 start while busy is ignored; host_we while not IDLE is ignored; host reads are allowed in every state.
REQ-029 Same-cycle write-back and host read to one address returns the old value.

Reset
REQ-030 rst_n low forces state IDLE, mask_we=0, mask_data=0, busy=0, done=0, converged=0, iter_count=0, changed=0, host_rdata=0, host_rharris=0, immediately and asynchronously; RAM contents are not reset.
REQ-031 Reset mid-run abandons the pass; after release the block stays in IDLE until start.

Structure
REQ-032 Shared package holds the FSM state enum and the derived constants FRAME_SIZE=N*N and STREAM_LEN=2*N*N.
REQ-033 One sub-module, frame_dualram (one write port, one host read port, one compare read port), instanced for pixel and harris storage.

Verification
REQ-034 Load a frame of all 0, run the mask model as identity -> DONE after 1 pass, iter_count=1, converged=1.
REQ-035 Mask model clears one pixel per pass on a 3-pixel line (N=8) -> iter_count=4, converged=1, final frame all 0.
REQ-036 Model always inverts pixel 9 with MAX_ITER=5 -> DONE, iter_count=5, converged=0.
REQ-037 Stream check: mask_we high for exactly 128 cycles, pixel k present on cycles 2k and 2k+1.
REQ-038 rst_n pulsed low at stream cycle 40 -> all outputs 0 that cycle, IDLE after release, frame RAM unchanged apart from completed writes.
REQ-039 Model never asserts mask_wr_en -> DONE 256 cycles after WAIT_WB entry, converged=0, iter_count=0.

Source files
------------

// File: rtl/skel_frame_server_pkg.sv
// Shared types and size helpers for the skeletonization frame server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package skel_frame_server_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STREAM  = 3'd1,
        S_WAIT_WB = 3'd2,
        S_CAPTURE = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Sizes for the default frame edge; the helpers give the same values for any edge.
    localparam int N_DEFAULT  = 8;
    localparam int FRAME_SIZE = N_DEFAULT * N_DEFAULT;
    localparam int STREAM_LEN = 2 * FRAME_SIZE;

    function automatic int frame_size(input int n);
        return n * n;
    endfunction

    // Each pixel is held for two cycles to match the convolution unit's half-rate flip.
    function automatic int stream_len(input int n);
        return 2 * n * n;
    endfunction

    // Cycles to wait for the first write-back beat before giving up on a pass.
    function automatic int wait_len(input int n);
        return 4 * n * n;
    endfunction

endpackage

// File: rtl/skel_frame_server_frame_dualram.sv
// Frame storage: one write port, one registered host read port, one combinational compare read port.
// Latency: host read 1 cycle (old data on same-cycle write), compare read 0 cycles.
// Backpressure: none; out-of-range addresses write nothing and read as zero.
// Ports: clk/rst_n; we/waddr/wdata write; raddr->rdata host read; caddr->cdata compare read.
module frame_dualram #(
    parameter int DEPTH = 64,
    parameter int AW    = 7,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [AW-1:0] caddr,
    output logic [DW-1:0] cdata
);

    localparam int            IW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic w_ok;
    logic r_ok;
    logic c_ok;

    assign w_ok = ({1'b0, waddr} < DEPTH_L);
    assign r_ok = ({1'b0, raddr} < DEPTH_L);
    assign c_ok = ({1'b0, caddr} < DEPTH_L);

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Registered read samples the array before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (r_ok) begin
            rdata <= mem[raddr[IW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

    assign cdata = c_ok ? mem[caddr[IW-1:0]] : '0;

endmodule

// File: rtl/skel_frame_server.sv
// Iterative skeletonization controller: streams the frame to a convolution unit, captures write-back, repeats until stable or capped.
// Latency: 2*N*N stream cycles per pass, then write-back burst, then 1 check cycle; host reads 1 cycle.
// Backpressure: none; write-back timeout of 4*N*N cycles ends the run unconverged.
// Ports: host_* frame load/read; start/busy/done/iter_count/converged control; mask_we/mask_data stream out; mask_wr_en/addr/pixel/harris write-back in.
module skel_frame_server
    import skel_frame_server_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int MAX_ITER   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_we,
    input  logic [bitSize:0]      host_addr,
    input  logic [pixelWidth-1:0] host_wdata,
    output logic [pixelWidth-1:0] host_rdata,
    output logic                  host_rharris,
    input  logic                  start,
    output logic                  mask_we,
    output logic [pixelWidth-1:0] mask_data,
    input  logic                  mask_wr_en,
    input  logic [bitSize:0]      mask_addr,
    input  logic [pixelWidth-1:0] mask_pixel,
    input  logic                  mask_harris,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            iter_count,
    output logic                  converged
);

    localparam int              FRAME      = frame_size(N);
    localparam int              SLEN       = stream_len(N);
    localparam int              WLEN       = wait_len(N);
    localparam int              AW         = bitSize + 1;
    localparam int              CW         = $clog2(WLEN + 1);
    localparam logic [CW-1:0]   SLEN_LAST  = CW'(SLEN - 1);
    localparam logic [CW-1:0]   WLEN_LAST  = CW'(WLEN - 1);
    localparam logic [AW:0]     FRAME_L    = (AW+1)'(FRAME);
    localparam logic [7:0]      MAX_ITER_L = 8'(MAX_ITER);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [7:0]      iter_nxt;
    logic            changed;
    logic            changed_nxt;
    logic            conv_nxt;

    logic                  host_hit;
    logic                  wb_hit;
    logic                  pix_we;
    logic [AW-1:0]         wr_addr;
    logic [pixelWidth-1:0] pix_wdata;
    logic [AW-1:0]         pix_caddr;
    logic [pixelWidth-1:0] pix_cdata;
    logic                  pix_diff;
    logic                  h_we;
    logic [0:0]            h_wdata;
    logic [0:0]            h_rdata;
    logic [0:0]            h_cdata;

    // ------------------------------------------------------------------
    // Write port arbitration: host load only in IDLE, write-back only while
    // waiting for or inside the burst, so the two never collide.
    // ------------------------------------------------------------------
    assign host_hit  = (state == S_IDLE) && host_we;
    assign wb_hit    = ((state == S_WAIT_WB) || (state == S_CAPTURE)) && mask_wr_en &&
                       ({1'b0, mask_addr} < FRAME_L);
    assign pix_we    = host_hit || wb_hit;
    assign wr_addr   = host_hit ? host_addr : mask_addr;
    assign pix_wdata = host_hit ? host_wdata : mask_pixel;

    // The compare port doubles as the stream source: it follows the stream
    // counter while streaming and the write-back address otherwise.
    assign pix_caddr = (state == S_STREAM) ? AW'(cnt >> 1) : mask_addr;
    assign pix_diff  = (pix_cdata != mask_pixel);

    // A freshly loaded frame has no corners. Write-back only touches the
    // corner array when the stored bit actually flips.
    assign h_we      = host_hit || (wb_hit && (h_cdata[0] != mask_harris));
    assign h_wdata   = host_hit ? 1'b0 : mask_harris;

    frame_dualram #(
        .DEPTH (FRAME),
        .AW    (AW),
        .DW    (pixelWidth)
    ) u_pix_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pix_we),
        .waddr (wr_addr),
        .wdata (pix_wdata),
        .raddr (host_addr),
        .rdata (host_rdata),
        .caddr (pix_caddr),
        .cdata (pix_cdata)
    );

    frame_dualram #(
        .DEPTH (FRAME),
        .AW    (AW),
        .DW    (1)
    ) u_harris_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (h_we),
        .waddr (wr_addr),
        .wdata (h_wdata),
        .raddr (host_addr),
        .rdata (h_rdata),
        .caddr (mask_addr),
        .cdata (h_cdata)
    );

    assign host_rharris = h_rdata[0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            iter_count <= '0;
            changed    <= 1'b0;
            converged  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            iter_count <= iter_nxt;
            changed    <= changed_nxt;
            converged  <= conv_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        iter_nxt    = iter_count;
        changed_nxt = changed;
        conv_nxt    = converged;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt   = S_STREAM;
                    cnt_nxt     = '0;
                    iter_nxt    = '0;
                    changed_nxt = 1'b0;
                    conv_nxt    = 1'b0;
                end
            end
            S_STREAM: begin
                if (cnt == SLEN_LAST) begin
                    state_nxt = S_WAIT_WB;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_WB: begin
                if (mask_wr_en) begin
                    state_nxt = S_CAPTURE;
                end else if (cnt == WLEN_LAST) begin
                    state_nxt = S_DONE;
                    conv_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!mask_wr_en) begin
                    state_nxt = S_CHECK;
                    if (iter_count != 8'hFF) begin
                        iter_nxt = iter_count + 8'd1;
                    end
                end
            end
            S_CHECK: begin
                if (changed && (iter_count < MAX_ITER_L)) begin
                    state_nxt   = S_STREAM;
                    cnt_nxt     = '0;
                    changed_nxt = 1'b0;
                end else begin
                    state_nxt = S_DONE;
                    conv_nxt  = ~changed;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // wb_hit is only true in WAIT_WB/CAPTURE, so this never fights the
        // clear in CHECK or the reset on start.
        if (wb_hit && pix_diff) begin
            changed_nxt = 1'b1;
        end
    end

    assign mask_we   = (state == S_STREAM);
    assign mask_data = mask_we ? pix_cdata : '0;
    assign busy      = (state == S_STREAM) || (state == S_WAIT_WB) ||
                       (state == S_CAPTURE) || (state == S_CHECK);
    assign done      = (state == S_DONE);

endmodule
